tests: RTL and testbench
========================

Name: tests

Overview:
- Self-checking built-in test block for the Karatsuba multiplier. The same block runs in simulation and on the Nexys A7 FPGA.
- It holds a 3-stage pipelined Karatsuba multiplier and a vector generator (fixed corner cases followed by LFSR operands). Each pipelined product is compared against a behavioural reference product.
- Outputs: pass/fail flags and an error counter, wired to LEDs on the FPGA.

Parameters:
- WIDTH, 16, operand width; must be even. Product width is 2*WIDTH.
- NUM_VECTORS, 32, total vectors: 8 fixed corner vectors, then LFSR vectors.
- LFSR_SEED, 32'hACE1_2468, initial LFSR state; must be non-zero.
- INJECT_FAULT_IDX, -1, fault injection control:
  - -1: no fault.
  - 0..NUM_VECTORS-1: invert bit 0 of the multiplier product for that vector only.
  - -2: invert bit 0 on every vector.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- all_passed  out  1  1 = run finished and zero mismatches.
- current_passed  out  1  result of the most recent comparison.
- info  out  4  mismatch counter, saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all_passed=0, current_passed=0, info=0, FSM=IDLE, vector index=0, LFSR=LFSR_SEED, pipeline valid bits=0.
- FSM states:
  - IDLE: one cycle, then RUN.
  - RUN: issues one vector per cycle for NUM_VECTORS cycles, then DRAIN.
  - DRAIN: waits until the pipeline valid bits are all 0, then DONE.
  - DONE: terminal; holds until rst_n asserts.
- Fixed vectors, index 0..7 (a, b): (0,0), (1,1), (MAX,MAX), (MAX,1), (1,MAX), (MAX,0), (1<<(WIDTH-1),2), (0x5555…,0xAAAA…). MAX = 2^WIDTH-1.
- LFSR vectors, index ≥8:
  - 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
  - a = lfsr[31:16], b = lfsr[15:0] for WIDTH=16; for other widths, the low bits of repeated LFSR words.
  - The LFSR advances once per issued LFSR vector.
- Multiplier, with h = WIDTH/2:
  - Split a = a1·2^h + a0 and b = b1·2^h + b0.
  - Stage 1: register the operands.
  - Stage 2: register z2 = a1·b1, z0 = a0·b0, and zm = (a1+a0)·(b1+b0). The sums are (h+1)-bit; zm is (2h+2)-bit.
  - Stage 3: register p = (z2<<2h) + ((zm−z2−z0)<<h) + z0, 2·WIDTH bits, no truncation.
  - Latency is 3 cycles from issue.
- Reference model:
  - The behavioural a*b of the same vector, delayed 3 cycles through matching registers.
  - A valid bit travels with each vector; comparisons occur only when the stage-3 valid bit is 1.
- Check (registered, on the cycle after stage-3 valid):
  - current_passed = (p == ref), where p has the fault inversion applied if selected.
  - On a mismatch, info increments, saturating at 15 with no wrap.
  - current_passed holds its value between checks and after DONE.
- all_passed:
  - Stays 0 until DONE.
  - In DONE, all_passed = (mismatch count == 0). The count used is the internal unsaturated "any error" flag, not info.
  - Asserts no later than NUM_VECTORS+6 rising edges after rst_n deasserts.
- Reset mid-run: all outputs return to reset values immediately (asynchronous). The sequence restarts from vector 0 with LFSR_SEED after release.

Test Plan:
- Release rst_n with defaults:
  - current_passed = 1 at every check.
  - all_passed = 1 within 38 cycles.
  - info = 0 and stays 0 for 100 further cycles.
- Probe the stage-3 product for vector 2 (0xFFFF×0xFFFF) → 0xFFFE0001.
- Probe vector 6 (0x8000×2) → 0x00010000.
- Probe vector 7 → 0x38E31C72.
- INJECT_FAULT_IDX=5:
  - current_passed = 0 for exactly one check.
  - info = 1.
  - all_passed stays 0 after DONE.
- INJECT_FAULT_IDX=-2:
  - info saturates at 15 and does not wrap.
  - current_passed = 0.
  - all_passed = 0.
- Assert rst_n low 10 cycles after release, hold 3 cycles, then release:
  - Outputs clear asynchronously while rst_n is low.
  - The rerun passes, with all_passed = 1 within 38 cycles of the second release.
- LFSR_SEED=32'h0000_0001: run completes with all_passed = 1.

Source files
------------

// File: rtl/tests.sv
// Built-in self test for a 3-stage pipelined Karatsuba multiplier: fixed corner
// vectors then LFSR operands, each product checked against a behavioural a*b.
module tests #(
  parameter int          WIDTH            = 16,
  parameter int          NUM_VECTORS      = 32,
  parameter logic [31:0] LFSR_SEED        = 32'hACE1_2468,
  parameter int          INJECT_FAULT_IDX = -1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       all_passed,
  output logic       current_passed,
  output logic [3:0] info
);

  localparam int H   = WIDTH / 2;
  localparam int PW  = 2 * WIDTH;
  localparam int IW  = (NUM_VECTORS > 8) ? $clog2(NUM_VECTORS) : 3;
  localparam int REP = (PW + 31) / 32;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            r_state, w_next;
  logic [IW-1:0]     r_idx;
  logic [31:0]       r_lfsr;
  logic              w_issue;
  logic              w_fault;
  logic [WIDTH-1:0]  w_a, w_b;
  logic [32*REP-1:0] w_cat;

  logic [WIDTH-1:0]  r_a1, r_b1;
  logic [PW-1:0]     r_ref1, r_ref2, r_ref3;
  logic              r_v1, r_v2, r_v3;
  logic              r_f1, r_f2, r_f3;
  logic [2*H-1:0]    r_z2, r_z0;
  logic [2*H+1:0]    r_zm;
  logic [PW-1:0]     r_p;
  logic [H:0]        w_sa, w_sb;
  logic [PW-1:0]     w_pOut;

  logic              r_cur;
  logic [3:0]        r_info;
  logic              r_anyErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = RUN;
      RUN:     if (r_idx == IW'(NUM_VECTORS - 1)) w_next = DRAIN;
      DRAIN:   if (!(r_v1 || r_v2 || r_v3)) w_next = DONE;
      default: w_next = DONE;
    endcase
  end

  always_comb begin
    w_issue    = (r_state == RUN);
    all_passed = (r_state == DONE) && !r_anyErr;
  end

  // Corner cases first; afterwards the LFSR word (repeated if WIDTH > 16) feeds both operands.
  assign w_cat = {REP{r_lfsr}};

  always_comb begin
    w_a = '0;
    w_b = '0;
    if (r_idx < IW'(8)) begin
      case (r_idx[2:0])
        3'd0: begin w_a = '0;         w_b = '0;         end
        3'd1: begin w_a = WIDTH'(1);  w_b = WIDTH'(1);  end
        3'd2: begin w_a = '1;         w_b = '1;         end
        3'd3: begin w_a = '1;         w_b = WIDTH'(1);  end
        3'd4: begin w_a = WIDTH'(1);  w_b = '1;         end
        3'd5: begin w_a = '1;         w_b = '0;         end
        3'd6: begin w_a = {1'b1, {(WIDTH-1){1'b0}}}; w_b = WIDTH'(2); end
        default: begin w_a = {H{2'b01}}; w_b = {H{2'b10}}; end
      endcase
    end else begin
      w_a = w_cat[PW-1:WIDTH];
      w_b = w_cat[WIDTH-1:0];
    end
  end

  assign w_fault = (INJECT_FAULT_IDX == -2) || (INJECT_FAULT_IDX == int'(r_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (w_issue) begin
      r_idx <= r_idx + IW'(1);
      if (r_idx >= IW'(8))
        r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);
    end
  end

  assign w_sa = {1'b0, r_a1[WIDTH-1:H]} + {1'b0, r_a1[H-1:0]};
  assign w_sb = {1'b0, r_b1[WIDTH-1:H]} + {1'b0, r_b1[H-1:0]};

  // Reference product and fault flag ride alongside the Karatsuba stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a1   <= '0;
      r_b1   <= '0;
      r_ref1 <= '0;
      r_ref2 <= '0;
      r_ref3 <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_f1   <= 1'b0;
      r_f2   <= 1'b0;
      r_f3   <= 1'b0;
      r_z2   <= '0;
      r_z0   <= '0;
      r_zm   <= '0;
      r_p    <= '0;
    end else begin
      r_a1   <= w_a;
      r_b1   <= w_b;
      r_ref1 <= PW'(w_a) * PW'(w_b);
      r_v1   <= w_issue;
      r_f1   <= w_issue && w_fault;

      r_z2   <= (2*H)'(r_a1[WIDTH-1:H]) * (2*H)'(r_b1[WIDTH-1:H]);
      r_z0   <= (2*H)'(r_a1[H-1:0]) * (2*H)'(r_b1[H-1:0]);
      r_zm   <= (2*H+2)'(w_sa) * (2*H+2)'(w_sb);
      r_ref2 <= r_ref1;
      r_v2   <= r_v1;
      r_f2   <= r_f1;

      r_p    <= (PW'(r_z2) << (2*H))
              + ((PW'(r_zm) - PW'(r_z2) - PW'(r_z0)) << H)
              + PW'(r_z0);
      r_ref3 <= r_ref2;
      r_v3   <= r_v2;
      r_f3   <= r_f2;
    end
  end

  assign w_pOut = r_p ^ {{(PW-1){1'b0}}, r_f3};

  // r_anyErr is the unsaturated record used for all_passed; r_info only feeds the LEDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur    <= 1'b0;
      r_info   <= 4'd0;
      r_anyErr <= 1'b0;
    end else if (r_v3) begin
      r_cur <= (w_pOut == r_ref3);
      if (w_pOut != r_ref3) begin
        r_anyErr <= 1'b1;
        if (r_info != 4'hF) r_info <= r_info + 4'd1;
      end
    end
  end

  assign current_passed = r_cur;
  assign info           = r_info;

endmodule

// File: tb/tb_tests.sv
// Directed bench for the Karatsuba self-test block: default run, fault injection,
// alternate seed and an asynchronous reset in the middle of a run.
module tb_tests;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rstAux_n;
  logic       mainAll, mainCur, f5All, f5Cur, faAll, faCur, s1All, s1Cur;
  logic [3:0] mainInfo, f5Info, faInfo, s1Info;
  int         testsRun  = 0;
  int         failCount = 0;
  vec_t       vecs[8];

  always #5 clk = ~clk;

  tests dut (
    .clk(clk), .rst_n(rst_n),
    .all_passed(mainAll), .current_passed(mainCur), .info(mainInfo)
  );

  tests #(.INJECT_FAULT_IDX(5)) dutFlt5 (
    .clk(clk), .rst_n(rstAux_n),
    .all_passed(f5All), .current_passed(f5Cur), .info(f5Info)
  );

  tests #(.INJECT_FAULT_IDX(-2)) dutFltAll (
    .clk(clk), .rst_n(rstAux_n),
    .all_passed(faAll), .current_passed(faCur), .info(faInfo)
  );

  tests #(.LFSR_SEED(32'h0000_0001)) dutSeed1 (
    .clk(clk), .rst_n(rstAux_n),
    .all_passed(s1All), .current_passed(s1Cur), .info(s1Info)
  );

  task automatic applyStimulus(input logic mainRst, input logic auxRst, input int cycles);
    rst_n    = mainRst;
    rstAux_n = auxRst;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 32'h0000_0000};
    vecs[1] = '{16'h0001, 16'h0001, 32'h0000_0001};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[3] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[5] = '{16'hFFFF, 16'h0000, 32'h0000_0000};
    vecs[6] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[7] = '{16'h5555, 16'hAAAA, 32'h38E3_1C72};

    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("rstAllPassed", 32'(mainAll), 32'd0);
    checkOutput("rstCurPassed", 32'(mainCur), 32'd0);
    checkOutput("rstInfo",      32'(mainInfo), 32'd0);
    checkOutput("rstAuxInfo",   32'(faInfo), 32'd0);

    // Vector k reaches stage 3 after edge 4+k and is checked after edge 5+k.
    rst_n    = 1'b1;
    rstAux_n = 1'b1;
    for (int n = 1; n <= 38; n++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (n >= 4 && n <= 11)
        checkOutput($sformatf("stage3Prod%0d", n - 4), dut.r_p, vecs[n-4].prod);
      if (n >= 5 && n <= 36) begin
        checkOutput($sformatf("mainCur%0d", n - 5), 32'(mainCur), 32'd1);
        checkOutput($sformatf("flt5Cur%0d", n - 5), 32'(f5Cur), (n == 10) ? 32'd0 : 32'd1);
        checkOutput($sformatf("fltAllCur%0d", n - 5), 32'(faCur), 32'd0);
        checkOutput($sformatf("seed1Cur%0d", n - 5), 32'(s1Cur), 32'd1);
      end
      if (n == 20)
        checkOutput("mainAllMidRun", 32'(mainAll), 32'd0);
    end
    checkOutput("mainAllPassed",  32'(mainAll), 32'd1);
    checkOutput("mainInfoEnd",    32'(mainInfo), 32'd0);
    checkOutput("flt5AllPassed",  32'(f5All), 32'd0);
    checkOutput("flt5Info",       32'(f5Info), 32'd1);
    checkOutput("fltAllInfo",     32'(faInfo), 32'd15);
    checkOutput("fltAllAll",      32'(faAll), 32'd0);
    checkOutput("seed1AllPassed", 32'(s1All), 32'd1);

    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (i % 10 == 0) begin
        checkOutput($sformatf("mainInfoHold%0d", i), 32'(mainInfo), 32'd0);
        checkOutput($sformatf("mainAllHold%0d", i), 32'(mainAll), 32'd1);
      end
    end
    checkOutput("fltAllInfoSat",  32'(faInfo), 32'd15);
    checkOutput("fltAllCurEnd",   32'(faCur), 32'd0);
    checkOutput("fltAllAllEnd",   32'(faAll), 32'd0);
    checkOutput("flt5AllEnd",     32'(f5All), 32'd0);
    checkOutput("flt5CurEnd",     32'(f5Cur), 32'd1);

    // Fresh run, then pull reset low mid-run between clock edges.
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("preResetCur", 32'(mainCur), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncCur",  32'(mainCur), 32'd0);
    checkOutput("asyncAll",  32'(mainAll), 32'd0);
    checkOutput("asyncInfo", 32'(mainInfo), 32'd0);
    checkOutput("asyncPipe", 32'(dut.r_v3), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("heldCur", 32'(mainCur), 32'd0);
    rst_n = 1'b1;
    for (int n = 1; n <= 38; n++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (n >= 4 && n <= 11)
        checkOutput($sformatf("rerunProd%0d", n - 4), dut.r_p, vecs[n-4].prod);
      if (n >= 5 && n <= 36)
        checkOutput($sformatf("rerunCur%0d", n - 5), 32'(mainCur), 32'd1);
    end
    checkOutput("rerunAllPassed", 32'(mainAll), 32'd1);
    checkOutput("rerunInfo",      32'(mainInfo), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
